// File: rtl/controller_sequencer_if.sv
// Control bus between the sequencer and the 8-bit CPU datapath.
//   opcode/zero : instruction nibble and accumulator-zero flag from the datapath
//   tstate      : one-hot T-state ring (bit0 = T1 ... bit5 = T6)
//   cp..lo      : datapath strobes; hlt = CPU halted
// master = sequencer side, slave = datapath side.
interface controller_sequencer_if;
    logic [3:0] opcode;
    logic       zero;
    logic [5:0] tstate;
    logic       cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

    modport master (
        input  opcode, zero,
        output tstate, cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt
    );
    modport slave (
        output opcode, zero,
        input  tstate, cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt
    );
endinterface

// File: rtl/controller_sequencer.sv
// T-state sequencer / micro-step decoder for the 8-bit CPU.
//   clk   : rising-edge clock
//   clr_n : synchronous active-low reset
//   bus   : master side of controller_sequencer_if (opcode/zero in, strobes out)
// A one-hot 6-state ring runs fetch (T1-T3) and execute (T4-T6). Strobes are a
// purely combinational decode of the ring, the halted flag, opcode and zero.
// SHORT_CYCLE=1 returns to T1 straight after an instruction's last active step.
module controller_sequencer #(
    parameter logic SHORT_CYCLE = 1'b0
) (
    input  logic                    clk,
    input  logic                    clr_n,
    controller_sequencer_if.master  bus
);
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JZ  = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [5:0] tstate;
    logic       halted;
    logic       onehot;
    logic       last_step;
    logic       cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    assign onehot = (tstate != 6'b0) && ((tstate & (tstate - 6'd1)) == 6'b0);

    // Short-cycle exits: LDA finishes at T5; everything except the ALU ops
    // (and HLT, which freezes instead) finishes at T4.
    always_comb begin
        last_step = 1'b0;
        if (SHORT_CYCLE) begin
            if (tstate == T5 && bus.opcode == OP_LDA)
                last_step = 1'b1;
            if (tstate == T4 && bus.opcode != OP_LDA && bus.opcode != OP_ADD &&
                bus.opcode != OP_SUB && bus.opcode != OP_HLT)
                last_step = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            tstate <= T1;
            halted <= 1'b0;
        end else if (halted) begin
            tstate <= T4;
        end else if (!onehot) begin
            tstate <= T1;
        end else if (tstate == T4 && bus.opcode == OP_HLT) begin
            tstate <= T4;
            halted <= 1'b1;
        end else if (last_step || tstate == T6) begin
            tstate <= T1;
        end else begin
            tstate <= {tstate[4:0], 1'b0};
        end
    end

    always_comb begin
        {cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo} = 13'b0;
        if (!halted) begin
            case (tstate)
                T1: begin ep = 1'b1; lm = 1'b1; end
                T2: cp = 1'b1;
                T3: begin ce = 1'b1; li = 1'b1; end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                        OP_JMP:                 begin ei = 1'b1; lp = 1'b1; end
                        OP_JZ:                  begin ei = bus.zero; lp = bus.zero; end
                        OP_OUT:                 begin ea = 1'b1; lo = 1'b1; end
                        default: ;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA:         begin ce = 1'b1; la = 1'b1; end
                        OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        eu = 1'b1;
                        la = 1'b1;
                        su = (bus.opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tstate = tstate;
    assign bus.hlt    = halted;
    assign bus.cp = cp;  assign bus.ep = ep;  assign bus.lp = lp;
    assign bus.lm = lm;  assign bus.ce = ce;  assign bus.li = li;
    assign bus.ei = ei;  assign bus.la = la;  assign bus.ea = ea;
    assign bus.su = su;  assign bus.eu = eu;  assign bus.lb = lb;
    assign bus.lo = lo;
endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: one DUT per SHORT_CYCLE setting, directed
// scenarios plus a random opcode stream checked against a table-driven model.
module tb_controller_sequencer;
    localparam logic [12:0] K_CP = 13'h1000, K_EP = 13'h0800, K_LP = 13'h0400,
                            K_LM = 13'h0200, K_CE = 13'h0100, K_LI = 13'h0080,
                            K_EI = 13'h0040, K_LA = 13'h0020, K_EA = 13'h0010,
                            K_SU = 13'h0008, K_EU = 13'h0004, K_LB = 13'h0002,
                            K_LO = 13'h0001;

    logic clk = 1'b0;
    logic clr_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    controller_sequencer_if i0 ();
    controller_sequencer_if i1 ();

    controller_sequencer #(.SHORT_CYCLE(1'b0)) dut0 (.clk(clk), .clr_n(clr_n), .bus(i0.master));
    controller_sequencer #(.SHORT_CYCLE(1'b1)) dut1 (.clk(clk), .clr_n(clr_n), .bus(i1.master));

    wire [12:0] ctl0 = {i0.cp, i0.ep, i0.lp, i0.lm, i0.ce, i0.li, i0.ei,
                        i0.la, i0.ea, i0.su, i0.eu, i0.lb, i0.lo};
    wire [12:0] ctl1 = {i1.cp, i1.ep, i1.lp, i1.lm, i1.ce, i1.li, i1.ei,
                        i1.la, i1.ea, i1.su, i1.eu, i1.lb, i1.lo};

    // Expected strobes for micro-step 1..6 of an instruction.
    function automatic logic [12:0] exp_ctl(input logic [3:0] op, input int step, input logic z);
        case (step)
            1: return K_EP | K_LM;
            2: return K_CP;
            3: return K_CE | K_LI;
            4: case (op)
                   4'h0, 4'h1, 4'h2: return K_EI | K_LM;
                   4'h3: return K_EI | K_LP;
                   4'h4: return z ? (K_EI | K_LP) : 13'h0;
                   4'hE: return K_EA | K_LO;
                   default: return 13'h0;
               endcase
            5: case (op)
                   4'h0: return K_CE | K_LA;
                   4'h1, 4'h2: return K_CE | K_LB;
                   default: return 13'h0;
               endcase
            6: case (op)
                   4'h1: return K_EU | K_LA;
                   4'h2: return K_EU | K_LA | K_SU;
                   default: return 13'h0;
               endcase
            default: return 13'h0;
        endcase
    endfunction

    // Instruction length in T-states (HLT excluded).
    function automatic int instr_len(input logic [3:0] op, input logic sc);
        if (!sc) return 6;
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
    endfunction

    task automatic set_in(input logic [3:0] op, input logic z);
        i0.opcode = op; i0.zero = z;
        i1.opcode = op; i1.zero = z;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(4'h5, 1'b0);
        do_reset();
        checks++; if (i0.tstate !== 6'h01) begin errors++; $display("FAIL reset_tstate0: got %h want 01", i0.tstate); end
        checks++; if (ctl0 !== (K_EP | K_LM)) begin errors++; $display("FAIL reset_ctl0: got %h want %h", ctl0, K_EP | K_LM); end
        checks++; if (i0.hlt !== 1'b0) begin errors++; $display("FAIL reset_hlt0: got %b want 0", i0.hlt); end
        checks++; if (i1.tstate !== 6'h01) begin errors++; $display("FAIL reset_tstate1: got %h want 01", i1.tstate); end
    endtask

    task automatic test_lda_cycle();
        logic [5:0]  ts [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        logic [12:0] cs [7] = '{K_EP | K_LM, K_CP, K_CE | K_LI, K_EI | K_LM, K_CE | K_LA, 13'h0, K_EP | K_LM};
        set_in(4'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            checks++; if (i0.tstate !== ts[i]) begin errors++; $display("FAIL lda_tstate[%0d]: got %h want %h", i, i0.tstate, ts[i]); end
            checks++; if (ctl0 !== cs[i]) begin errors++; $display("FAIL lda_ctl[%0d]: got %h want %h", i, ctl0, cs[i]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        set_in(4'h1, 1'b0);
        do_reset();
        repeat (4) tick();
        checks++; if (ctl0 !== (K_CE | K_LB)) begin errors++; $display("FAIL add_t5: got %h want %h", ctl0, K_CE | K_LB); end
        tick();
        checks++; if (ctl0 !== (K_EU | K_LA)) begin errors++; $display("FAIL add_t6: got %h want %h", ctl0, K_EU | K_LA); end
        tick();
        set_in(4'h2, 1'b0);
        checks++; if (i0.tstate !== 6'h01) begin errors++; $display("FAIL add_wrap: got %h want 01", i0.tstate); end
        repeat (4) tick();
        checks++; if (ctl0 !== (K_CE | K_LB)) begin errors++; $display("FAIL sub_t5: got %h want %h", ctl0, K_CE | K_LB); end
        tick();
        checks++; if (ctl0 !== (K_EU | K_LA | K_SU)) begin errors++; $display("FAIL sub_t6: got %h want %h", ctl0, K_EU | K_LA | K_SU); end
    endtask

    task automatic test_jz();
        // Full-length DUT: zero=0 then zero=1.
        set_in(4'h4, 1'b0);
        do_reset();
        repeat (3) tick();
        checks++; if (i0.lp !== 1'b0 || ctl0 !== 13'h0) begin errors++; $display("FAIL jz0_t4: got %h want 0000", ctl0); end
        repeat (3) tick();
        set_in(4'h4, 1'b1);
        repeat (3) tick();
        checks++; if (ctl0 !== (K_EI | K_LP)) begin errors++; $display("FAIL jz1_t4: got %h want %h", ctl0, K_EI | K_LP); end
        tick();
        checks++; if (ctl0 !== 13'h0) begin errors++; $display("FAIL jz1_t5: got %h want 0000", ctl0); end
        // Short-cycle DUT: both variants are 4-state instructions.
        set_in(4'h4, 1'b0);
        do_reset();
        repeat (3) tick();
        checks++; if (i1.tstate !== 6'h08 || ctl1 !== 13'h0) begin errors++; $display("FAIL sc_jz0_t4: got %h/%h want 08/0000", i1.tstate, ctl1); end
        tick();
        checks++; if (i1.tstate !== 6'h01) begin errors++; $display("FAIL sc_jz0_end: got %h want 01", i1.tstate); end
        set_in(4'h4, 1'b1);
        repeat (3) tick();
        checks++; if (ctl1 !== (K_EI | K_LP)) begin errors++; $display("FAIL sc_jz1_t4: got %h want %h", ctl1, K_EI | K_LP); end
        tick();
        checks++; if (i1.tstate !== 6'h01) begin errors++; $display("FAIL sc_jz1_end: got %h want 01", i1.tstate); end
    endtask

    task automatic test_halt();
        set_in(4'hF, 1'b0);
        do_reset();
        repeat (3) tick();
        checks++; if (i0.tstate !== 6'h08 || i0.hlt !== 1'b0 || ctl0 !== 13'h0) begin
            errors++; $display("FAIL hlt_t4: got %h/%b/%h want 08/0/0000", i0.tstate, i0.hlt, ctl0); end
        for (int i = 0; i < 22; i++) begin
            tick();
            checks++; if (i0.tstate !== 6'h08 || i0.hlt !== 1'b1 || ctl0 !== 13'h0) begin
                errors++; $display("FAIL hlt_hold[%0d]: got %h/%b/%h want 08/1/0000", i, i0.tstate, i0.hlt, ctl0); end
            checks++; if (i1.tstate !== 6'h08 || i1.hlt !== 1'b1 || ctl1 !== 13'h0) begin
                errors++; $display("FAIL sc_hlt_hold[%0d]: got %h/%b/%h want 08/1/0000", i, i1.tstate, i1.hlt, ctl1); end
        end
        do_reset();
        checks++; if (i0.tstate !== 6'h01 || i0.hlt !== 1'b0 || ctl0 !== (K_EP | K_LM)) begin
            errors++; $display("FAIL hlt_exit: got %h/%b/%h want 01/0/%h", i0.tstate, i0.hlt, ctl0, K_EP | K_LM); end
    endtask

    task automatic test_reset_mid_instr();
        set_in(4'h1, 1'b0);
        do_reset();
        repeat (4) tick();
        checks++; if (i0.tstate !== 6'h10) begin errors++; $display("FAIL mid_t5: got %h want 10", i0.tstate); end
        do_reset();
        checks++; if (i0.tstate !== 6'h01 || ctl0 !== (K_EP | K_LM)) begin
            errors++; $display("FAIL mid_after: got %h/%h want 01/%h", i0.tstate, ctl0, K_EP | K_LM); end
        tick();
        checks++; if (ctl0 !== K_CP) begin errors++; $display("FAIL mid_next: got %h want %h", ctl0, K_CP); end
    endtask

    task automatic test_random();
        logic [3:0] op0, op1;
        int s0, s1, n0, n1;
        logic z;
        logic [4:0] drv;
        set_in(4'h0, 1'b0);
        do_reset();
        s0 = 1; s1 = 1; op0 = 4'h0; op1 = 4'h0;
        for (int c = 0; c < 1000; c++) begin
            if (s0 == 1) op0 = 4'($urandom_range(0, 14));
            if (s1 == 1) op1 = 4'($urandom_range(0, 14));
            z = 1'($urandom);
            i0.opcode = op0; i0.zero = z;
            i1.opcode = op1; i1.zero = z;
            #1;
            checks++; if (i0.tstate !== 6'(1 << (s0 - 1)) || ctl0 !== exp_ctl(op0, s0, z)) begin
                errors++; $display("FAIL rnd0[%0d] op %h step %0d: got %h/%h want %h/%h", c, op0, s0, i0.tstate, ctl0, 6'(1 << (s0 - 1)), exp_ctl(op0, s0, z)); end
            checks++; if (i1.tstate !== 6'(1 << (s1 - 1)) || ctl1 !== exp_ctl(op1, s1, z)) begin
                errors++; $display("FAIL rnd1[%0d] op %h step %0d: got %h/%h want %h/%h", c, op1, s1, i1.tstate, ctl1, 6'(1 << (s1 - 1)), exp_ctl(op1, s1, z)); end
            checks++; if (!$onehot(i0.tstate) || !$onehot(i1.tstate)) begin
                errors++; $display("FAIL rnd_onehot[%0d]: got %h/%h want one-hot", c, i0.tstate, i1.tstate); end
            drv = {i0.ep, i0.ce, i0.ei, i0.ea, i0.eu};
            checks++; if ($countones(drv) > 1) begin errors++; $display("FAIL rnd_bus0[%0d]: got %b want <=1 driver", c, drv); end
            drv = {i1.ep, i1.ce, i1.ei, i1.ea, i1.eu};
            checks++; if ($countones(drv) > 1) begin errors++; $display("FAIL rnd_bus1[%0d]: got %b want <=1 driver", c, drv); end
            checks++; if ((i0.cp & i0.lp) !== 1'b0 || (i1.cp & i1.lp) !== 1'b0) begin
                errors++; $display("FAIL rnd_cp_lp[%0d]: got %b%b/%b%b want not both", c, i0.cp, i0.lp, i1.cp, i1.lp); end
            n0 = (s0 == instr_len(op0, 1'b0)) ? 1 : s0 + 1;
            n1 = (s1 == instr_len(op1, 1'b1)) ? 1 : s1 + 1;
            @(posedge clk); #1;
            s0 = n0; s1 = n1;
        end
    endtask

    initial begin
        test_reset();
        test_lda_cycle();
        test_back_to_back();
        test_jz();
        test_halt();
        test_reset_mid_instr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
